// File: rtl/dcsg_write_sequencer.sv
// Buffers CPU OUT cycles to I/O C0h-C7h in a small FIFO and replays each byte to the
// 76489 DCSG as a CE_N/WE_N strobe paced by the DCSG READY handshake.
module dcsg_write_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PTR_WIDTH     = 2,
    parameter logic [15:0] READY_TIMEOUT = 16'd4000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [9:0]           address,
    input  logic                 x_io_or_m,
    input  logic                 iow_n,
    input  logic [7:0]           data_in,
    input  logic                 dcsg_ready,
    output logic                 dcsg_ce_n,
    output logic                 dcsg_we_n,
    output logic [7:0]           dcsg_data,
    output logic                 cpu_ready,
    output logic [PTR_WIDTH:0]   fifo_level,
    output logic                 overflow,
    output logic                 timeout,
    input  logic                 clear_flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT_RDY,
        S_RELEASE
    } state_t;

    localparam logic [PTR_WIDTH:0] DEPTH_L = (PTR_WIDTH + 1)'(FIFO_DEPTH);

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_WIDTH:0]   level_q, level_d;
    logic                 wr_act, wr_act_q;
    logic [7:0]           wr_byte_q;
    logic [15:0]          timer_q, timer_d;
    state_t               state_q, state_d;
    logic [7:0]           data_q, data_d;
    logic                 ovf_q, ovf_d, to_q, to_d;
    logic                 full, empty, push, pop, push_ok, to_hit;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^address[2:0];

    assign wr_act  = x_io_or_m & (address[9:3] == 7'h18) & ~iow_n;
    assign full    = (level_q == DEPTH_L);
    assign empty   = (level_q == '0);
    assign push    = wr_act_q & ~wr_act;
    assign pop     = (state_q == S_RELEASE);
    // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign to_hit  = (timer_q == READY_TIMEOUT - 16'd1);

    assign cpu_ready  = ~(wr_act & full);
    assign fifo_level = level_q;
    assign dcsg_data  = data_q;
    assign overflow   = ovf_q;
    assign timeout    = to_q;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + (PTR_WIDTH + 1)'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - (PTR_WIDTH + 1)'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        data_d    = data_q;
        to_d      = to_q & ~clear_flags;
        ovf_d     = (ovf_q & ~clear_flags) | (push & full & ~pop);
        dcsg_ce_n = 1'b1;
        dcsg_we_n = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty && dcsg_ready) begin
                    state_d = S_SETUP;
                    data_d  = mem_q[rd_ptr_q];
                end
            end
            S_SETUP: begin
                dcsg_ce_n = 1'b0;
                timer_d   = '0;
                state_d   = S_STROBE;
            end
            S_STROBE, S_WAIT_RDY: begin
                dcsg_ce_n = 1'b0;
                dcsg_we_n = 1'b0;
                timer_d   = timer_q + 16'd1;
                if (to_hit) begin
                    state_d = S_RELEASE;
                    to_d    = 1'b1;
                end else if (state_q == S_STROBE && !dcsg_ready) begin
                    state_d = S_WAIT_RDY;
                end else if (state_q == S_WAIT_RDY && dcsg_ready) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            to_q      <= 1'b0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            wr_act_q  <= 1'b0;
            wr_byte_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            level_q  <= level_d;
            wr_act_q <= wr_act;
            if (wr_act) begin
                wr_byte_q <= data_in;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_byte_q;
        end
    end

endmodule

// File: tb/tb_dcsg_write_sequencer.sv
// Directed and randomized bench for dcsg_write_sequencer: a DCSG responder drives READY,
// and a monitor compares replayed bytes against a queue of accepted CPU writes.
module tb_dcsg_write_sequencer;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] address = '0;
    logic       x_io_or_m = 1'b0;
    logic       iow_n = 1'b1;
    logic [7:0] data_in = '0;
    logic       dcsg_ready = 1'b1;
    logic       clear_flags = 1'b0;
    logic       dcsg_ce_n, dcsg_we_n, cpu_ready, overflow, timeout;
    logic [7:0] dcsg_data;
    logic [2:0] fifo_level;

    dcsg_write_sequencer #(
        .FIFO_DEPTH(4),
        .PTR_WIDTH(2),
        .READY_TIMEOUT(16'd4000)
    ) dut (
        .clock(clock), .reset_n(reset_n), .address(address), .x_io_or_m(x_io_or_m),
        .iow_n(iow_n), .data_in(data_in), .dcsg_ready(dcsg_ready), .dcsg_ce_n(dcsg_ce_n),
        .dcsg_we_n(dcsg_we_n), .dcsg_data(dcsg_data), .cpu_ready(cpu_ready),
        .fifo_level(fifo_level), .overflow(overflow), .timeout(timeout),
        .clear_flags(clear_flags)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int rmode = 0;          // 0 = responsive DCSG, 1 = READY held low, 2 = READY stuck high
    int busy_len = 32;
    int busy_cnt = 0;
    bit responded = 0;
    int last_ce_len = 0;
    int ce_len = 0;
    int high_cnt = 100;
    bit in_str = 0;
    logic [7:0] str_data = '0;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // DCSG responder: pulls READY low busy_len clocks after each WE_N assertion.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rmode == 1) dcsg_ready = 1'b0;
            else if (rmode == 2) dcsg_ready = 1'b1;
            else begin
                if (dcsg_ce_n) responded = 0;
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    dcsg_ready = (busy_cnt == 0);
                end else if (!dcsg_we_n && !responded) begin
                    busy_cnt = busy_len;
                    responded = 1;
                    dcsg_ready = 1'b0;
                end else dcsg_ready = 1'b1;
            end
        end
    end

    // Strobe monitor: records each replayed byte and checks strobe shape.
    always @(negedge clock) begin
        if (!reset_n) begin
            in_str = 0;
            high_cnt = 100;
        end else if (!dcsg_ce_n) begin
            if (!in_str) begin
                chk("idle_gap", 32'(high_cnt >= 2), 1);
                in_str = 1;
                ce_len = 1;
                str_data = dcsg_data;
                obs_q.push_back(dcsg_data);
            end else begin
                ce_len++;
                chk("data_stable", dcsg_data, str_data);
            end
        end else begin
            chk("we_inside_ce", dcsg_we_n, 1);
            if (in_str) begin
                chk("data_release", dcsg_data, str_data);
                in_str = 0;
                last_ce_len = ce_len;
                high_cnt = 1;
            end else high_cnt++;
        end
    end

    // One CPU OUT cycle; the model queues the byte if it is decoded and has room.
    task automatic cpu_out(input logic [9:0] a, input logic io, input logic [7:0] d,
                           input int lowclks, input bit honor);
        int g;
        bit sel;
        @(posedge clock);
        #1;
        address = a; x_io_or_m = io; data_in = d; iow_n = 1'b0;
        repeat (lowclks) begin @(posedge clock); #1; end
        g = 0;
        while (honor && !cpu_ready && g < 5000) begin @(posedge clock); #1; g++; end
        if (honor) chk("cpu_ready_wait", 32'(g < 5000), 1);
        iow_n = 1'b1; data_in = ~d;
        sel = io && (a >= 10'h0C0) && (a <= 10'h0C7);
        if (sel && (honor || (exp_q.size() - obs_q.size()) < DEPTH)) exp_q.push_back(d);
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        @(negedge clock);
        while (!(fifo_level == 0 && dcsg_ce_n && !in_str) && g < 20000) begin
            @(negedge clock); g++;
        end
        chk("drain_bound", 32'(g < 20000), 1);
        repeat (2) @(negedge clock);
    endtask

    task automatic cmp_q(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_byte"}, obs_q[i], exp_q[i]);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic pulse_clear();
        @(posedge clock); #1 clear_flags = 1'b1;
        @(posedge clock); #1 clear_flags = 1'b0;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b5 [5];
        logic [9:0] a;
        logic io;
        int g;
        b5[0] = 8'h90; b5[1] = 8'hA0; b5[2] = 8'hB0; b5[3] = 8'hC0; b5[4] = 8'hD0;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("rst_ce_n", dcsg_ce_n, 1);
        chk("rst_we_n", dcsg_we_n, 1);
        chk("rst_data", dcsg_data, 8'h00);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);

        // Single OUT with a 32-clock READY low pulse
        rmode = 0; busy_len = 32;
        cpu_out(10'h0C0, 1'b1, 8'h9F, 2, 1'b1);
        @(negedge clock);
        chk("t1_level_after_push", fifo_level, 1);
        drain();
        cmp_q("t1");
        chk("t1_ce_len", last_ce_len, 34);
        chk("t1_timeout", timeout, 0);

        // Address decode: only C7h lands
        rmode = 1;
        cpu_out(10'h0C7, 1'b1, 8'h5A, 2, 1'b0);
        @(negedge clock) chk("t5_level_c7", fifo_level, 1);
        cpu_out(10'h0BF, 1'b1, 8'h11, 2, 1'b0);
        @(negedge clock) chk("t5_level_bf", fifo_level, 1);
        cpu_out(10'h0C8, 1'b1, 8'h22, 2, 1'b0);
        @(negedge clock) chk("t5_level_c8", fifo_level, 1);
        cpu_out(10'h0C0, 1'b0, 8'h33, 2, 1'b0);
        @(negedge clock) chk("t5_level_mem", fifo_level, 1);
        rmode = 0; busy_len = 3;
        drain();
        cmp_q("t5");

        // Full FIFO stretches the fifth write until a slot frees
        rmode = 1;
        for (int i = 0; i < 4; i++) cpu_out(10'h0C0, 1'b1, b5[i], 2, 1'b1);
        @(negedge clock) chk("t2_level_full", fifo_level, 4);
        @(posedge clock);
        #1 address = 10'h0C0; x_io_or_m = 1'b1; data_in = b5[4]; iow_n = 1'b0;
        @(negedge clock);
        chk("t2_cpu_ready_low", cpu_ready, 0);
        @(posedge clock);
        #1 rmode = 0; busy_len = 6;
        g = 0;
        while (!cpu_ready && g < 2000) begin @(posedge clock); #1; g++; end
        chk("t2_ready_back", 32'(g < 2000), 1);
        iow_n = 1'b1; data_in = 8'h00;
        exp_q.push_back(b5[4]);
        @(posedge clock);
        drain();
        cmp_q("t2");
        chk("t2_overflow", overflow, 0);

        // CPU ignores cpu_ready: fifth byte dropped
        rmode = 1;
        for (int i = 0; i < 5; i++) cpu_out(10'h0C1, 1'b1, b5[i], 2, 1'b0);
        @(negedge clock);
        chk("t3_level", fifo_level, 4);
        chk("t3_overflow_set", overflow, 1);
        pulse_clear();
        @(negedge clock) chk("t3_overflow_clr", overflow, 0);
        rmode = 0; busy_len = 4;
        drain();
        cmp_q("t3");

        // READY never goes low: forced release after the timeout
        rmode = 2;
        cpu_out(10'h0C3, 1'b1, 8'h55, 1, 1'b1);
        drain();
        cmp_q("t4");
        chk("t4_ce_len", last_ce_len, 4001);
        chk("t4_timeout_set", timeout, 1);
        chk("t4_level", fifo_level, 0);
        pulse_clear();
        @(negedge clock) chk("t4_timeout_clr", timeout, 0);

        // Randomized traffic against the queue model
        rmode = 0;
        for (int n = 0; n < 30; n++) begin
            busy_len = $urandom_range(1, 12);
            if ($urandom_range(0, 9) < 7) a = 10'h0C0 + 10'($urandom_range(0, 7));
            else a = 10'($urandom_range(0, 1023));
            io = ($urandom_range(0, 9) != 0);
            cpu_out(a, io, 8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end
        drain();
        cmp_q("rand");
        chk("rand_overflow", overflow, 0);
        chk("rand_timeout", timeout, 0);

        // Asynchronous reset during WAIT_RDY with three queued
        rmode = 1;
        for (int i = 0; i < 3; i++) cpu_out(10'h0C2, 1'b1, b5[i], 2, 1'b0);
        @(negedge clock) chk("t6_level_pre", fifo_level, 3);
        @(posedge clock);
        #1 rmode = 0; busy_len = 50;
        g = 0;
        while (!(dcsg_we_n == 1'b0 && dcsg_ready == 1'b0) && g < 200) begin
            @(posedge clock); #1; g++;
        end
        chk("t6_reach_wait", 32'(g < 200), 1);
        repeat (3) @(posedge clock);
        #3;
        chk("t6_in_strobe", {dcsg_ce_n, dcsg_we_n}, 2'b00);
        reset_n = 1'b0;
        #1;
        chk("t6_ce_n", dcsg_ce_n, 1);
        chk("t6_we_n", dcsg_we_n, 1);
        chk("t6_level", fifo_level, 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        exp_q.delete();
        obs_q.delete();
        repeat (60) @(posedge clock);
        @(negedge clock);
        chk("t6_no_strobe", obs_q.size(), 0);
        chk("t6_level_after", fifo_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
